// File: rtl/heart_rate_calculator_if.sv
// heart_rate_calculator_if: RR-interval input and BPM result bundle for heart_rate_calculator.
//  master: drives i_rr_interval/i_rr_valid, observes results.
//  slave : the calculator; consumes the RR stream, drives bpm, flags and status pulses.
//  HRV_EN: when defined, adds o_rr_delta/o_rr_delta_valid.
interface heart_rate_calculator_if;
    logic [15:0] i_rr_interval;
    logic        i_rr_valid;
    logic [7:0]  o_bpm;
    logic        o_bpm_valid;
    logic        o_brady;
    logic        o_tachy;
    logic        o_rr_reject;
    logic        o_overrun;
    logic        o_busy;
`ifdef HRV_EN
    logic [15:0] o_rr_delta;
    logic        o_rr_delta_valid;
`endif
    modport master (
        output i_rr_interval, i_rr_valid,
        input  o_bpm, o_bpm_valid, o_brady, o_tachy, o_rr_reject, o_overrun, o_busy
`ifdef HRV_EN
        , input o_rr_delta, o_rr_delta_valid
`endif
    );
    modport slave (
        input  i_rr_interval, i_rr_valid,
        output o_bpm, o_bpm_valid, o_brady, o_tachy, o_rr_reject, o_overrun, o_busy
`ifdef HRV_EN
        , output o_rr_delta, o_rr_delta_valid
`endif
    );
endinterface

// File: rtl/heart_rate_calculator.sv
// heart_rate_calculator: range-checks Q4.11 RR intervals, keeps a moving-average window and
//  computes BPM = 60/RR with a 17-cycle restoring divider, flagging brady/tachycardia.
//  clk    : system clock
//  rst_n  : synchronous reset, active-low
//  bus    : heart_rate_calculator_if.slave
//           i_rr_interval/i_rr_valid in; o_bpm, o_bpm_valid, o_brady, o_tachy,
//           o_rr_reject, o_overrun, o_busy out
//  HRV_EN : when defined, adds o_rr_delta = |rr_new - previous accepted rr| with o_rr_delta_valid.
module heart_rate_calculator #(
    parameter int          AVG_DEPTH = 8,
    parameter logic [15:0] RR_MIN    = 16'h0200,
    parameter logic [15:0] RR_MAX    = 16'h1800,
    parameter int          BRADY_BPM = 60,
    parameter int          TACHY_BPM = 100
) (
    input logic                    clk,
    input logic                    rst_n,
    heart_rate_calculator_if.slave bus
);
    localparam int          LG       = $clog2(AVG_DEPTH);
    localparam int          SW       = 16 + LG;
    localparam logic [16:0] DIVIDEND = 17'd122880;
    localparam logic [LG:0] FULL     = (LG+1)'(AVG_DEPTH);
    localparam logic [7:0]  BRADY8   = 8'(BRADY_BPM);
    localparam logic [7:0]  TACHY8   = 8'(TACHY_BPM);

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;
    state_t r_state, w_next;

    logic [15:0]   r_buf [AVG_DEPTH];
    logic [SW-1:0] r_sum;
    logic [LG:0]   r_count;
    logic [LG-1:0] r_ptr;
    logic [15:0]   r_rr_new, r_divisor, r_rem;
    logic [16:0]   r_quo;
    logic [4:0]    r_cycle;
    logic [7:0]    r_bpm;
    logic          r_bpm_valid, r_brady, r_tachy, r_reject, r_overrun;

    logic [15:0] w_rr;
    logic        w_in_range, w_accept, w_ge;
    logic [16:0] w_trial;
    logic [15:0] w_rem_nxt;
    logic [7:0]  w_bpm_sat;

    assign w_rr       = bus.i_rr_interval;
    assign w_in_range = !w_rr[15] && w_rr >= RR_MIN && w_rr <= RR_MAX;
    assign w_accept   = r_state == IDLE && bus.i_rr_valid && w_in_range;
    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    assign w_trial    = {r_rem, r_quo[16]};
    assign w_ge       = w_trial >= {1'b0, r_divisor};
    assign w_rem_nxt  = w_ge ? 16'(w_trial - {1'b0, r_divisor}) : w_trial[15:0];
    assign w_bpm_sat  = |r_quo[16:8] ? 8'hFF : r_quo[7:0];

    always_ff @(posedge clk)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? ACCUM : IDLE;
            ACCUM:   w_next = DIVIDE;
            DIVIDE:  w_next = r_cycle == 5'd16 ? DONE : DIVIDE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < AVG_DEPTH; i++) r_buf[i] <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_ptr       <= '0;
            r_rr_new    <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cycle     <= '0;
            r_bpm       <= '0;
            r_bpm_valid <= 1'b0;
            r_brady     <= 1'b0;
            r_tachy     <= 1'b0;
            r_reject    <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_bpm_valid <= 1'b0;
            r_reject    <= r_state == IDLE && bus.i_rr_valid && !w_in_range;
            r_overrun   <= r_state != IDLE && bus.i_rr_valid;
            if (w_accept) begin
                // Buffer starts zeroed, so the evicted entry contributes 0 until the window fills.
                r_buf[r_ptr] <= w_rr;
                r_sum        <= r_sum + SW'(w_rr) - SW'(r_buf[r_ptr]);
                r_ptr        <= r_ptr + 1'b1;
                r_count      <= r_count == FULL ? FULL : r_count + 1'b1;
                r_rr_new     <= w_rr;
            end
            case (r_state)
                ACCUM: begin
                    r_divisor <= r_count == FULL ? r_sum[LG +: 16] : r_rr_new;
                    r_quo     <= DIVIDEND;
                    r_rem     <= '0;
                    r_cycle   <= '0;
                end
                DIVIDE: begin
                    r_rem   <= w_rem_nxt;
                    r_quo   <= {r_quo[15:0], w_ge};
                    r_cycle <= r_cycle + 1'b1;
                end
                DONE: begin
                    r_bpm       <= w_bpm_sat;
                    r_brady     <= w_bpm_sat < BRADY8;
                    r_tachy     <= w_bpm_sat > TACHY8;
                    r_bpm_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HRV_EN
    logic [15:0] r_prev, r_delta_pend, r_rr_delta;
    logic        r_have_prev, r_delta_ok, r_rr_delta_valid;

    // Delta is captured at acceptance and published alongside the BPM result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev           <= '0;
            r_delta_pend     <= '0;
            r_rr_delta       <= '0;
            r_have_prev      <= 1'b0;
            r_delta_ok       <= 1'b0;
            r_rr_delta_valid <= 1'b0;
        end else begin
            r_rr_delta_valid <= 1'b0;
            if (w_accept) begin
                r_delta_pend <= w_rr >= r_prev ? w_rr - r_prev : r_prev - w_rr;
                r_delta_ok   <= r_have_prev;
                r_prev       <= w_rr;
                r_have_prev  <= 1'b1;
            end
            if (r_state == DONE) begin
                r_rr_delta       <= r_delta_pend;
                r_rr_delta_valid <= r_delta_ok;
            end
        end
    end

    assign bus.o_rr_delta       = r_rr_delta;
    assign bus.o_rr_delta_valid = r_rr_delta_valid;
`endif

    assign bus.o_bpm       = r_bpm;
    assign bus.o_bpm_valid = r_bpm_valid;
    assign bus.o_brady     = r_brady;
    assign bus.o_tachy     = r_tachy;
    assign bus.o_rr_reject = r_reject;
    assign bus.o_overrun   = r_overrun;
    assign bus.o_busy      = r_state != IDLE;
endmodule

// File: tb/tb_heart_rate_calculator.sv
// tb_heart_rate_calculator: scoreboard bench; stimulus pushes expected results, a monitor pops on o_bpm_valid.
module tb_heart_rate_calculator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   last_cyc = 0;
    int   exp_rej = 0, seen_rej = 0;
    int   exp_ovr = 0, seen_ovr = 0;

    typedef struct {
        int bpm;
        bit brady;
        bit tachy;
        int at;
        bit chk_d;
        bit dv;
        int delta;
    } exp_t;
    exp_t q[$];

    heart_rate_calculator_if bus();
    heart_rate_calculator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns just after the sampling edge.
    task automatic send(input logic [15:0] rr);
        bus.i_rr_interval = rr;
        bus.i_rr_valid = 1'b1;
        @(posedge clk);
        #1;
        last_cyc = cyc;
        bus.i_rr_valid = 1'b0;
    endtask

    task automatic expect_bpm(input int b, input bit br, input bit ta);
        exp_t e;
        e.bpm = b; e.brady = br; e.tachy = ta; e.at = last_cyc + 19;
        e.chk_d = 1'b0; e.dv = 1'b0; e.delta = 0;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.o_busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic run(input logic [15:0] rr, input int b, input bit br, input bit ta);
        send(rr);
        expect_bpm(b, br, ta);
        wait_idle();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_bpm_valid) begin
                if (q.size() == 0) chk("unexpected_bpm_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("bpm", int'(bus.o_bpm), e.bpm);
                    chk("brady", int'(bus.o_brady), int'(e.brady));
                    chk("tachy", int'(bus.o_tachy), int'(e.tachy));
                    chk("latency_cycle", cyc, e.at);
`ifdef HRV_EN
                    if (e.chk_d) begin
                        chk("rr_delta_valid", int'(bus.o_rr_delta_valid), int'(e.dv));
                        if (e.dv) chk("rr_delta", int'(bus.o_rr_delta), e.delta);
                    end
`endif
                end
            end
            if (bus.o_rr_reject) seen_rej++;
            if (bus.o_overrun) seen_ovr++;
        end
    end

    initial begin
        bus.i_rr_interval = '0;
        bus.i_rr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bpm", int'(bus.o_bpm), 0);
        chk("rst_bpm_valid", int'(bus.o_bpm_valid), 0);
        chk("rst_brady", int'(bus.o_brady), 0);
        chk("rst_tachy", int'(bus.o_tachy), 0);
        chk("rst_reject", int'(bus.o_rr_reject), 0);
        chk("rst_overrun", int'(bus.o_overrun), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(16'h0800, 60, 0, 0);
        run(16'h0400, 120, 0, 1);
        run(16'h1000, 30, 1, 0);

        send(16'h0100); exp_rej++; wait_idle();
        send(16'h1900); exp_rej++; wait_idle();
        send(16'h8800); exp_rej++; wait_idle();
        run(16'h0200, 240, 0, 1);
        run(16'h1800, 20, 1, 0);

        do_reset();
        for (int i = 0; i < 7; i++) run(16'h0800, 60, 0, 0);
        run(16'h0400, 64, 0, 0);
        run(16'h0400, 68, 0, 0);

        do_reset();
        send(16'h0800);
        expect_bpm(60, 0, 0);
        repeat (5) @(negedge clk);
        send(16'h0800);
        exp_ovr++;
        wait_idle();
        for (int i = 0; i < 5; i++) run(16'h0800, 60, 0, 0);
        run(16'h0400, 120, 0, 1);

        send(16'h0800);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", int'(bus.o_busy), 0);
        chk("midrst_bpm", int'(bus.o_bpm), 0);
        chk("midrst_tachy", int'(bus.o_tachy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        send(16'h0800);
        expect_bpm(60, 0, 0);
        q[q.size()-1].chk_d = 1'b1;
        wait_idle();
        send(16'h0600);
        expect_bpm(80, 0, 0);
        q[q.size()-1].chk_d = 1'b1;
        q[q.size()-1].dv = 1'b1;
        q[q.size()-1].delta = 'h200;
        wait_idle();

        repeat (25) @(negedge clk);
        chk("pending_results", q.size(), 0);
        chk("reject_pulses", seen_rej, exp_rej);
        chk("overrun_pulses", seen_ovr, exp_ovr);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
